// File: rtl/bp_me_nonsynth_mem_responder_pkg.sv
// Shared types for the CCE-facing memory responder: the memory message layout,
// message/size encodings and the responder state encoding.
package bp_me_nonsynth_mem_responder_pkg;

   localparam int paddr_width_p       = 40;
   localparam int cce_block_width_p   = 512;
   localparam int payload_width_p     = 16;
   localparam int block_bytes_lp      = cce_block_width_p / 8;
   localparam int mem_offset_width_lp = $clog2(block_bytes_lp);

   typedef enum logic [3:0] {
      e_mem_msg_rd    = 4'b0000,
      e_mem_msg_wr    = 4'b0001,
      e_mem_msg_uc_rd = 4'b0010,
      e_mem_msg_uc_wr = 4'b0011
   } bp_mem_msg_e;

   typedef enum logic [2:0] {
      e_mem_size_1  = 3'd0,
      e_mem_size_2  = 3'd1,
      e_mem_size_4  = 3'd2,
      e_mem_size_8  = 3'd3,
      e_mem_size_16 = 3'd4,
      e_mem_size_32 = 3'd5,
      e_mem_size_64 = 3'd6
   } bp_mem_msg_size_e;

   typedef struct packed {
      logic [cce_block_width_p-1:0] data;
      logic [payload_width_p-1:0]   payload;
      bp_mem_msg_size_e             size;
      logic [paddr_width_p-1:0]     addr;
      bp_mem_msg_e                  msg_type;
   } bp_cce_mem_msg_s;

   localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_wait = 2'd1,
      e_resp = 2'd2
   } bp_me_mem_responder_state_e;

   // Sizes beyond a whole block are meaningless for uncached access; cap at one block.
   function automatic logic [2:0] uc_size_clamp(input logic [2:0] size);
      return (size > 3'd6) ? 3'd6 : size;
   endfunction

endpackage

// File: rtl/bp_me_nonsynth_mem_byte_array.sv
// Zero-initialised array of cache blocks with byte-masked write and
// combinational whole-block read; writes land on the clock edge, so a read in
// the same cycle still sees the old contents.
module bp_me_nonsynth_mem_byte_array
   import bp_me_nonsynth_mem_responder_pkg::*;
#(
   parameter int els_p   = 64,
   parameter int width_p = cce_block_width_p,
   localparam int idx_w_lp = $clog2(els_p),
   localparam int bytes_lp = width_p / 8
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                w_v_i,
   input  logic [idx_w_lp-1:0] w_idx_i,
   input  logic [bytes_lp-1:0] w_mask_i,
   input  logic [width_p-1:0]  w_data_i,
   input  logic [idx_w_lp-1:0] r_idx_i,
   output logic [width_p-1:0]  r_data_o
);

   logic [width_p-1:0] blk_rd [els_p];

   generate
      for (genvar gi = 0; gi < els_p; gi++) begin : g_blk
         logic [width_p-1:0] blk_q;

         // Clear on reset, otherwise update only the enabled bytes of the addressed block.
         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               blk_q <= '0;
            end else if (w_v_i && (w_idx_i == idx_w_lp'(gi))) begin
               for (int b = 0; b < bytes_lp; b++) begin
                  if (w_mask_i[b]) begin
                     blk_q[b*8 +: 8] <= w_data_i[b*8 +: 8];
                  end
               end
            end
         end

         assign blk_rd[gi] = blk_q;
      end
   endgenerate

   assign r_data_o = blk_rd[r_idx_i];

endmodule

// File: rtl/bp_me_nonsynth_mem_responder.sv
// Single-outstanding memory responder: accepts one mem_cmd in IDLE, commits any
// write immediately, then after latency_p cycles presents the response and holds
// it until the CCE takes it.
module bp_me_nonsynth_mem_responder
   import bp_me_nonsynth_mem_responder_pkg::*;
#(
   parameter int mem_els_p = 64,
   parameter int latency_p = 4
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
   input  logic                            mem_cmd_v_i,
   output logic                            mem_cmd_yumi_o,
   output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
   output logic                            mem_resp_v_o,
   input  logic                            mem_resp_ready_i
);

   localparam int blk_idx_w_lp = $clog2(mem_els_p);
   localparam int cnt_w_lp     = (latency_p < 1) ? 1 : $clog2(latency_p + 1);
   localparam int off_w_lp     = mem_offset_width_lp;

   bp_cce_mem_msg_s             cmd;
   bp_cce_mem_msg_s             resp_d;
   bp_cce_mem_msg_s             resp_q;
   bp_me_mem_responder_state_e  state_q;
   logic [cnt_w_lp-1:0]         cnt_q;
   logic                        resp_v_q;

   logic                        yumi;
   logic [blk_idx_w_lp-1:0]     cmd_blk;
   logic [2:0]                  uc_size;
   logic [off_w_lp:0]           uc_bytes;
   logic [off_w_lp-1:0]         uc_off;
   logic [block_bytes_lp-1:0]   uc_mask;
   logic [block_bytes_lp-1:0]   uc_keep;
   logic [cce_block_width_p-1:0] uc_wdata;
   logic [cce_block_width_p-1:0] rd_data;
   logic [cce_block_width_p-1:0] rd_shifted;
   logic [cce_block_width_p-1:0] uc_rdata;
   logic                        w_v;
   logic [block_bytes_lp-1:0]   w_mask;
   logic [cce_block_width_p-1:0] w_data;

   assign cmd = mem_cmd_i;

   // Accept only while idle; reset blocks acceptance so nothing is consumed or written.
   assign yumi           = (state_q == e_idle) & mem_cmd_v_i & ~reset_i;
   assign mem_cmd_yumi_o = yumi;

   // Higher address bits above the block index are ignored, so the array wraps.
   assign cmd_blk  = cmd.addr[off_w_lp +: blk_idx_w_lp];

   // Uncached window: power-of-two bytes, start aligned down to the access size.
   assign uc_size  = uc_size_clamp(cmd.size);
   assign uc_bytes = (off_w_lp + 1)'(1) << uc_size;
   assign uc_off   = cmd.addr[off_w_lp-1:0] & ~off_w_lp'(uc_bytes - (off_w_lp + 1)'(1));

   generate
      for (genvar gi = 0; gi < block_bytes_lp; gi++) begin : g_uc_byte
         assign uc_mask[gi] = ((off_w_lp + 1)'(gi) >= {1'b0, uc_off})
                            && ((off_w_lp + 1)'(gi) < ({1'b0, uc_off} + uc_bytes));
         assign uc_keep[gi] = ((off_w_lp + 1)'(gi) < uc_bytes);
         assign uc_rdata[gi*8 +: 8] = uc_keep[gi] ? rd_shifted[gi*8 +: 8] : 8'h00;
      end
   endgenerate

   assign uc_wdata   = cmd.data << {uc_off, 3'b000};
   assign rd_shifted = rd_data >> {uc_off, 3'b000};

   assign w_v    = yumi & ((cmd.msg_type == e_mem_msg_wr) | (cmd.msg_type == e_mem_msg_uc_wr));
   assign w_mask = (cmd.msg_type == e_mem_msg_wr) ? {block_bytes_lp{1'b1}} : uc_mask;
   assign w_data = (cmd.msg_type == e_mem_msg_wr) ? cmd.data : uc_wdata;

   bp_me_nonsynth_mem_byte_array #(
      .els_p   (mem_els_p),
      .width_p (cce_block_width_p)
   ) mem (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .w_v_i    (w_v),
      .w_idx_i  (cmd_blk),
      .w_mask_i (w_mask),
      .w_data_i (w_data),
      .r_idx_i  (cmd_blk),
      .r_data_o (rd_data)
   );

   // Response echoes the command header; only reads return data, everything else returns zero.
   always_comb begin
      resp_d      = cmd;
      resp_d.data = '0;
      case (cmd.msg_type)
         e_mem_msg_rd:    resp_d.data = rd_data;
         e_mem_msg_uc_rd: resp_d.data = uc_rdata;
         default:         resp_d.data = '0;
      endcase
   end

   // Responder FSM: capture on accept, count down latency, hold response until handshake.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= e_idle;
         cnt_q    <= '0;
         resp_q   <= '0;
         resp_v_q <= 1'b0;
      end else begin
         case (state_q)
            e_idle: begin
               if (yumi) begin
                  resp_q <= resp_d;
                  cnt_q  <= cnt_w_lp'(latency_p);
                  if (latency_p == 0) begin
                     state_q  <= e_resp;
                     resp_v_q <= 1'b1;
                  end else begin
                     state_q <= e_wait;
                  end
               end
            end
            e_wait: begin
               if (cnt_q == cnt_w_lp'(1)) begin
                  state_q  <= e_resp;
                  resp_v_q <= 1'b1;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q - cnt_w_lp'(1);
               end
            end
            e_resp: begin
               if (resp_v_q && mem_resp_ready_i) begin
                  state_q  <= e_idle;
                  resp_v_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= e_idle;
               resp_v_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_resp_o   = resp_q;
   assign mem_resp_v_o = resp_v_q;

endmodule

// File: tb/tb_bp_me_nonsynth_mem_responder.sv
// Bench for the memory responder: a latency-4 instance driven through directed
// and random commands against a byte-level memory model, plus a latency-0
// instance for sustained-throughput checks.
module tb_bp_me_nonsynth_mem_responder;
   import bp_me_nonsynth_mem_responder_pkg::*;

   logic clk = 1'b0;
   logic reset;

   bp_cce_mem_msg_s cmd0, resp0, cmd1, resp1;
   logic v0, yumi0, resp_v0, ready0;
   logic v1, yumi1, resp_v1, ready1;

   int errors = 0;
   int checks = 0;

   logic [cce_block_width_p-1:0] blk_m [64];

   always #5 clk = ~clk;

   bp_me_nonsynth_mem_responder #(.mem_els_p(64), .latency_p(4)) dut0 (
      .clk_i            (clk),
      .reset_i          (reset),
      .mem_cmd_i        (cmd0),
      .mem_cmd_v_i      (v0),
      .mem_cmd_yumi_o   (yumi0),
      .mem_resp_o       (resp0),
      .mem_resp_v_o     (resp_v0),
      .mem_resp_ready_i (ready0)
   );

   bp_me_nonsynth_mem_responder #(.mem_els_p(64), .latency_p(0)) dut1 (
      .clk_i            (clk),
      .reset_i          (reset),
      .mem_cmd_i        (cmd1),
      .mem_cmd_v_i      (v1),
      .mem_cmd_yumi_o   (yumi1),
      .mem_resp_o       (resp1),
      .mem_resp_v_o     (resp_v1),
      .mem_resp_ready_i (ready1)
   );

   function automatic logic [cce_block_width_p-1:0] rand_blk();
      logic [cce_block_width_p-1:0] d;
      for (int i = 0; i < cce_block_width_p / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic bp_cce_mem_msg_s mk(input bp_mem_msg_e t, input logic [39:0] a,
                                          input logic [2:0] s,
                                          input logic [cce_block_width_p-1:0] d);
      bp_cce_mem_msg_s c;
      c.msg_type = t;
      c.addr     = a;
      c.size     = bp_mem_msg_size_e'(s);
      c.payload  = 16'($urandom);
      c.data     = d;
      return c;
   endfunction

   // Reference memory: apply a command to the byte model and return the response it should produce.
   function automatic bp_cce_mem_msg_s model_apply(input bp_cce_mem_msg_s c);
      bp_cce_mem_msg_s r;
      int idx, nb, off;
      r      = c;
      r.data = '0;
      idx    = int'(c.addr[11:6]);
      nb     = 1 << int'(c.size);
      off    = (int'(c.addr[5:0]) / nb) * nb;
      case (c.msg_type)
         e_mem_msg_rd:    r.data = blk_m[idx];
         e_mem_msg_wr:    blk_m[idx] = c.data;
         e_mem_msg_uc_rd: for (int i = 0; i < nb; i++) r.data[i*8 +: 8] = blk_m[idx][(off+i)*8 +: 8];
         e_mem_msg_uc_wr: for (int i = 0; i < nb; i++) blk_m[idx][(off+i)*8 +: 8] = c.data[i*8 +: 8];
         default: ;
      endcase
      return r;
   endfunction

   // Drive one command on dut0, measure accept-to-valid latency, optionally stall the response.
   task automatic run_cmd(input bp_cce_mem_msg_s c, input int stall, output bit got,
                          output int lat, output bp_cce_mem_msg_s r, output bit stable);
      int w;
      got = 1'b0; lat = 0; r = '0; stable = 1'b1;
      @(negedge clk);
      cmd0 = c; v0 = 1'b1; ready0 = (stall == 0);
      #1;
      w = 0;
      while (!yumi0 && w < 20) begin @(negedge clk); #1; w++; end
      if (!yumi0) begin v0 = 1'b0; ready0 = 1'b1; return; end
      @(negedge clk);
      v0 = 1'b0; lat = 1;
      #1;
      while (!resp_v0 && lat < 50) begin @(negedge clk); #1; lat++; end
      if (!resp_v0) begin ready0 = 1'b1; return; end
      r = resp0;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk); #1;
         if (!resp_v0 || resp0 !== r) stable = 1'b0;
      end
      ready0 = 1'b1;
      got = 1'b1;
      $display("txn type=%0h addr=%h size=%0d stall=%0d lat=%0d data_lo=%h",
               c.msg_type, c.addr, c.size, stall, lat, r.data[63:0]);
   endtask

   task automatic test_reset();
      reset = 1'b1; v0 = 1'b1; v1 = 1'b1;
      cmd0 = mk(e_mem_msg_wr, 40'h0, 3'd6, rand_blk());
      cmd1 = cmd0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (yumi0 !== 1'b0) begin errors++; $display("FAIL reset_yumi0 got=%b exp=0", yumi0); end
      checks++; if (resp_v0 !== 1'b0) begin errors++; $display("FAIL reset_resp_v0 got=%b exp=0", resp_v0); end
      checks++; if (resp0 !== '0) begin errors++; $display("FAIL reset_resp0 got=%h exp=0", resp0.data[63:0]); end
      checks++; if (yumi1 !== 1'b0 || resp_v1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 yumi=%b v=%b exp=0/0", yumi1, resp_v1); end
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) blk_m[i] = '0;
   endtask

   task automatic test_rd_after_reset();
      bp_cce_mem_msg_s c, e, r; bit got, st; int lat;
      c = mk(e_mem_msg_rd, 40'h0, 3'd6, rand_blk());
      e = model_apply(c);
      run_cmd(c, 0, got, lat, r, st);
      checks++; if (!got) begin errors++; $display("FAIL rd0_handshake got=0 exp=1"); end
      checks++; if (lat != 5) begin errors++; $display("FAIL rd0_latency got=%0d exp=5", lat); end
      checks++; if (r !== e) begin errors++; $display("FAIL rd0_resp got=%h/%h exp=%h/%h", r.addr, r.data[63:0], e.addr, e.data[63:0]); end
      checks++; if (r.data !== '0) begin errors++; $display("FAIL rd0_zero got=%h exp=0", r.data[63:0]); end
   endtask

   task automatic test_uc();
      bp_cce_mem_msg_s c, e, r; bit got, st; int lat;
      logic [cce_block_width_p-1:0] d;
      d = rand_blk(); d[7:0] = 8'h3C;
      c = mk(e_mem_msg_uc_wr, 40'h83, 3'd0, d);
      e = model_apply(c);
      run_cmd(c, 0, got, lat, r, st);
      checks++; if (!got || r !== e) begin errors++; $display("FAIL ucwr_resp got=%h exp=%h", r.data[63:0], e.data[63:0]); end
      c = mk(e_mem_msg_uc_rd, 40'h80, 3'd3, rand_blk());
      e = model_apply(c);
      run_cmd(c, 0, got, lat, r, st);
      checks++; if (!got || r !== e) begin errors++; $display("FAIL ucrd_resp got=%h exp=%h", r.data[63:0], e.data[63:0]); end
      checks++; if (r.data[63:0] !== 64'h0000_0000_3C00_0000 || r.data[511:64] !== '0) begin
         errors++; $display("FAIL ucrd_value got=%h exp=00000000_3c000000", r.data[63:0]);
      end
   endtask

   task automatic test_wr_rd();
      bp_cce_mem_msg_s c, e, r; bit got, st; int lat;
      c = mk(e_mem_msg_wr, 40'h80, 3'd6, {64{8'hA5}});
      e = model_apply(c);
      run_cmd(c, 0, got, lat, r, st);
      checks++; if (!got || lat != 5 || r !== e) begin errors++; $display("FAIL wr_resp lat=%0d data=%h exp lat=5 data=%h", lat, r.data[63:0], e.data[63:0]); end
      c = mk(e_mem_msg_rd, 40'h80, 3'd6, rand_blk());
      e = model_apply(c);
      run_cmd(c, 0, got, lat, r, st);
      checks++; if (!got || r.data !== {64{8'hA5}} || r !== e) begin errors++; $display("FAIL rd_after_wr got=%h exp=%h", r.data[63:0], {8{8'hA5}}); end
   endtask

   task automatic test_backpressure();
      bp_cce_mem_msg_s c1, c2, e1, e2, held;
      int lat, early;
      c1 = mk(e_mem_msg_rd, 40'h80, 3'd6, rand_blk());
      c2 = mk(e_mem_msg_uc_rd, 40'h84, 3'd2, rand_blk());
      @(negedge clk);
      cmd0 = c1; v0 = 1'b1; ready0 = 1'b0;
      #1;
      checks++; if (yumi0 !== 1'b1) begin errors++; $display("FAIL bp_first_yumi got=%b exp=1", yumi0); end
      e1 = model_apply(c1);
      @(negedge clk);
      cmd0 = c2; lat = 1; early = 0;
      #1;
      while (!resp_v0 && lat < 50) begin
         if (yumi0) early++;
         @(negedge clk); #1; lat++;
      end
      checks++; if (lat != 5 || early != 0) begin errors++; $display("FAIL bp_wait lat=%0d yumis=%0d exp 5/0", lat, early); end
      checks++; if (resp0 !== e1) begin errors++; $display("FAIL bp_resp1 got=%h exp=%h", resp0.data[63:0], e1.data[63:0]); end
      held = resp0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         checks++;
         if (resp_v0 !== 1'b1 || resp0 !== held || yumi0 !== 1'b0) begin
            errors++; $display("FAIL bp_hold cycle=%0d v=%b yumi=%b stable=%b exp 1/0/1", k, resp_v0, yumi0, resp0 === held);
         end
      end
      ready0 = 1'b1;
      @(negedge clk); #1;
      checks++; if (yumi0 !== 1'b1 || resp_v0 !== 1'b0) begin errors++; $display("FAIL bp_second_accept yumi=%b v=%b exp 1/0", yumi0, resp_v0); end
      e2 = model_apply(c2);
      @(negedge clk);
      v0 = 1'b0; lat = 1;
      #1;
      while (!resp_v0 && lat < 50) begin @(negedge clk); #1; lat++; end
      checks++; if (lat != 5 || resp0 !== e2) begin errors++; $display("FAIL bp_resp2 lat=%0d got=%h exp=%h", lat, resp0.data[63:0], e2.data[63:0]); end
      $display("txn backpressure rd+uc_rd resp2_lo=%h", resp0.data[63:0]);
   endtask

   task automatic test_random();
      bp_cce_mem_msg_s c, e, r; bit got, st; int lat, t, s, stall;
      logic [39:0] a;
      for (int n = 0; n < 40; n++) begin
         t = $urandom_range(0, 4);
         a = 40'({$urandom, $urandom});
         a[11:6] = 6'($urandom_range(0, 7));
         s = (t == 2 || t == 3) ? $urandom_range(0, 3) : $urandom_range(0, 6);
         c = mk((t == 4) ? bp_mem_msg_e'(4'hB) : bp_mem_msg_e'(t), a, 3'(s), rand_blk());
         stall = $urandom_range(0, 3);
         e = model_apply(c);
         run_cmd(c, stall, got, lat, r, st);
         checks++;
         if (!got || lat != 5 || !st || r !== e) begin
            errors++;
            $display("FAIL rand_%0d got=%b lat=%0d stable=%b data=%h exp data=%h", n, got, lat, st, r.data[63:0], e.data[63:0]);
         end
      end
   endtask

   task automatic test_zero_latency();
      bp_cce_mem_msg_s c;
      int acc;
      c = mk(e_mem_msg_rd, 40'h1234_5678_C0, 3'd6, rand_blk());
      acc = 0;
      @(negedge clk);
      cmd1 = c; v1 = 1'b1; ready1 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (yumi1) acc++;
         checks++;
         if (yumi1 !== ((k % 2) == 0) || resp_v1 !== ((k % 2) == 1)) begin
            errors++; $display("FAIL zl_cycle_%0d yumi=%b v=%b exp %b/%b", k, yumi1, resp_v1, (k % 2) == 0, (k % 2) == 1);
         end
         if (resp_v1) begin
            checks++;
            if (resp1.data !== '0 || resp1.addr !== c.addr || resp1.payload !== c.payload) begin
               errors++; $display("FAIL zl_resp_%0d addr=%h data=%h exp addr=%h data=0", k, resp1.addr, resp1.data[63:0], c.addr);
            end
         end
         @(negedge clk);
      end
      v1 = 1'b0;
      checks++; if (acc != 10) begin errors++; $display("FAIL zl_throughput got=%0d exp=10", acc); end
      $display("txn zero_latency accepts=%0d in 20 cycles", acc);
   endtask

   task automatic test_reset_mid();
      bp_cce_mem_msg_s c, e, r; bit got, st; int lat, vseen;
      c = mk(e_mem_msg_wr, 40'h140, 3'd6, rand_blk());
      e = model_apply(c);
      run_cmd(c, 0, got, lat, r, st);
      checks++; if (!got) begin errors++; $display("FAIL rm_write got=0 exp=1"); end
      @(negedge clk);
      cmd0 = mk(e_mem_msg_rd, 40'h140, 3'd6, rand_blk()); v0 = 1'b1;
      #1;
      checks++; if (yumi0 !== 1'b1) begin errors++; $display("FAIL rm_accept got=%b exp=1", yumi0); end
      @(negedge clk); v0 = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      #1;
      checks++; if (resp0 !== '0) begin errors++; $display("FAIL rm_resp_cleared got=%h exp=0", resp0.data[63:0]); end
      vseen = 0;
      for (int k = 0; k < 8; k++) begin
         if (resp_v0) vseen++;
         @(negedge clk); #1;
      end
      checks++; if (vseen != 0) begin errors++; $display("FAIL rm_no_resp got=%0d valid cycles exp=0", vseen); end
      for (int i = 0; i < 64; i++) blk_m[i] = '0;
      c = mk(e_mem_msg_rd, 40'h140, 3'd6, rand_blk());
      e = model_apply(c);
      run_cmd(c, 0, got, lat, r, st);
      checks++; if (!got || r !== e || r.data !== '0) begin errors++; $display("FAIL rm_rd_zero got=%h exp=0", r.data[63:0]); end
   endtask

   initial begin
      reset = 1'b1; v0 = 1'b0; v1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
      cmd0 = '0; cmd1 = '0;
      test_reset();
      test_rd_after_reset();
      test_uc();
      test_wr_rd();
      test_backpressure();
      test_random();
      test_zero_latency();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
